// File: rtl/vga_plot_sink_if.sv
// Pixel-write bus from the drawers plus the raster readout stream.
interface vga_plot_sink_if #(
  parameter int COLOUR_W = 3
);
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                scan_start;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_x;
  logic [6:0]          out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                scan_done;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, scan_start, out_ready,
    input  out_valid, out_x, out_y, out_colour, scan_done
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, scan_start, out_ready,
    output out_valid, out_x, out_y, out_colour, scan_done
  );
endinterface

// File: rtl/vga_plot_sink.sv
// Framebuffer sink for the drawer pixel bus: clears itself after reset,
// stores in-range plots, counts accepted/dropped plots, and streams the
// frame back in raster order with valid/ready backpressure.
module vga_plot_sink #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int COLOUR_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_plot_sink_if.slave bus,
  output logic           busy,
  output logic [15:0]    plot_count,
  output logic [15:0]    drop_count
);
  localparam int NPIX = WIDTH * HEIGHT;
  // One extra code so the clear counter can sit on NPIX for a final cycle.
  localparam int AW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN} state_t;
  state_t state, state_nxt;

  logic [COLOUR_W-1:0] mem [NPIX];

  logic [AW-1:0]       clr_addr;
  logic                clr_last;
  logic                in_range, plot_ok, plot_drop;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [COLOUR_W-1:0] wdata;

  logic [7:0]          gen_x;
  logic [6:0]          gen_y;
  logic [AW-1:0]       gen_addr;
  logic                gen_done;

  logic                vld_p1;
  logic [7:0]          x_p1;
  logic [6:0]          y_p1;
  logic [AW-1:0]       addr_p1;

  logic                adv_p1, adv_p2, accept_last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return AW'(y) * AW'(WIDTH) + AW'(x);
  endfunction

  // Range check uses the raw bus bits, so wrapped negative coordinates drop.
  assign in_range  = (int'(bus.vga_x) < WIDTH) && (int'(bus.vga_y) < HEIGHT);
  assign plot_ok   = bus.vga_plot && (state != S_CLEAR) && in_range;
  assign plot_drop = bus.vga_plot && !plot_ok;
  assign clr_last  = (clr_addr == AW'(NPIX));
  assign busy      = (state == S_CLEAR);

  assign adv_p2      = !bus.out_valid || bus.out_ready;
  assign adv_p1      = adv_p2 || !vld_p1;
  assign accept_last = (state == S_SCAN) && bus.out_valid && bus.out_ready &&
                       (bus.out_x == 8'(WIDTH - 1)) && (bus.out_y == 7'(HEIGHT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // Next-state: clear sweep, wait for a scan request, stream until last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_last)       state_nxt = S_IDLE;
      S_IDLE:  if (bus.scan_start) state_nxt = S_SCAN;
      S_SCAN:  if (accept_last)    state_nxt = S_IDLE;
      default:                     state_nxt = S_CLEAR;
    endcase
  end

  // Clear sweep address, one location per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                              clr_addr <= '0;
    else if (state == S_CLEAR && !clr_last)  clr_addr <= clr_addr + AW'(1);
  end

  // Write-port mux: the clear sweep owns the port while busy.
  always_comb begin
    we    = plot_ok;
    waddr = pix_addr(bus.vga_x, bus.vga_y);
    wdata = bus.vga_colour;
    if (state == S_CLEAR) begin
      we    = !clr_last;
      waddr = clr_addr;
      wdata = '0;
    end
  end

  // Framebuffer write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Saturating plot/drop counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plot_count <= '0;
      drop_count <= '0;
    end else begin
      if (plot_ok)   plot_count <= sat_inc(plot_count);
      if (plot_drop) drop_count <= sat_inc(drop_count);
    end
  end

  // ---- stage p1: raster address generator issues one read request per advance
  // Raster position counter and request-valid control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gen_x    <= '0;
      gen_y    <= '0;
      gen_addr <= '0;
      gen_done <= 1'b1;
      vld_p1   <= 1'b0;
    end else if (state == S_IDLE && bus.scan_start) begin
      gen_x    <= '0;
      gen_y    <= '0;
      gen_addr <= '0;
      gen_done <= 1'b0;
    end else if (state == S_SCAN && adv_p1) begin
      vld_p1 <= !gen_done;
      if (!gen_done) begin
        gen_addr <= gen_addr + AW'(1);
        if (gen_x == 8'(WIDTH - 1)) begin
          gen_x <= '0;
          if (gen_y == 7'(HEIGHT - 1)) gen_done <= 1'b1;
          else                         gen_y    <= gen_y + 7'd1;
        end else begin
          gen_x <= gen_x + 8'd1;
        end
      end
    end
  end

  // Request payload for stage p1.
  always_ff @(posedge clk) begin
    if (state == S_SCAN && adv_p1 && !gen_done) begin
      x_p1    <= gen_x;
      y_p1    <= gen_y;
      addr_p1 <= gen_addr;
    end
  end

  // ---- stage p2: synchronous memory read into the held output register
  // Output beat register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.out_colour <= '0;
    end else if (adv_p2) begin
      bus.out_valid <= vld_p1;
      if (vld_p1) begin
        bus.out_x      <= x_p1;
        bus.out_y      <= y_p1;
        bus.out_colour <= mem[addr_p1];
      end
    end
  end

  // One-cycle completion pulse after the final beat is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) bus.scan_done <= 1'b0;
    else        bus.scan_done <= accept_last;
  end
endmodule

// File: tb/tb_vga_plot_sink.sv
// Directed bench for vga_plot_sink: clear timing, plot acceptance/drops,
// backpressured readout, plot/read collisions, circle plot stream, abort.
module tb_vga_plot_sink;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] plot_count, drop_count;

  vga_plot_sink_if #(.COLOUR_W(3)) bus();

  vga_plot_sink #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .plot_count (plot_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [2:0] fb  [NPIX];
  logic [2:0] cap [NPIX];
  int beats, done_cnt, order_err, stall_err, first_lat, done_lat;
  bit timeout;
  logic valid_at_done;

  task automatic plot_one(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.vga_x = x; bus.vga_y = y; bus.vga_colour = c; bus.vga_plot = 1'b1;
    @(posedge clk); #1;
    bus.vga_plot = 1'b0;
  endtask

  // Runs one readout and records beats; mode 0 = ready high, 1 = toggling + random stalls.
  task automatic scan_collect(input int mode, input bit collide, input int abort_at);
    bit held, did_a, did_b;
    logic [7:0] hx; logic [6:0] hy; logic [2:0] hc;
    int last_acc, cyc;
    beats = 0; done_cnt = 0; order_err = 0; stall_err = 0;
    first_lat = -1; done_lat = -1; timeout = 0; valid_at_done = 1'b0;
    held = 0; did_a = 0; did_b = 0; last_acc = 0;
    hx = '0; hy = '0; hc = '0;
    bus.out_ready = (mode == 0);
    bus.scan_start = 1'b1;
    @(posedge clk); #1;
    bus.scan_start = 1'b0;
    for (cyc = 0; cyc < 60000; cyc++) begin
      if (bus.scan_done === 1'b1) begin
        done_cnt++;
        if (done_lat < 0) begin done_lat = cyc - last_acc; valid_at_done = bus.out_valid; end
      end
      if (bus.out_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (held && (bus.out_valid !== 1'b1 || bus.out_x !== hx || bus.out_y !== hy ||
                   bus.out_colour !== hc)) stall_err++;
      if (beats == NPIX && cyc - last_acc > 4) break;
      if (abort_at > 0 && beats == abort_at) begin rst_n = 1'b0; break; end
      if (mode == 0)      bus.out_ready = 1'b1;
      else if (cyc < 16)  bus.out_ready = (cyc % 2 == 0);
      else                bus.out_ready = ($urandom_range(0, 7) != 0);
      bus.vga_plot = 1'b0;
      if (collide && !did_a && beats >= 10) begin
        bus.vga_x = 8'd0; bus.vga_y = 7'd0; bus.vga_colour = 3'b110; bus.vga_plot = 1'b1; did_a = 1;
      end else if (collide && !did_b && beats >= 100) begin
        bus.vga_x = 8'd0; bus.vga_y = 7'd119; bus.vga_colour = 3'b101; bus.vga_plot = 1'b1; did_b = 1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (bus.out_x !== 8'(beats % W) || bus.out_y !== 7'(beats / W)) order_err++;
        if (beats < NPIX) cap[beats] = bus.out_colour;
        beats++;
        last_acc = cyc;
        held = 0;
      end else begin
        held = (bus.out_valid === 1'b1);
        hx = bus.out_x; hy = bus.out_y; hc = bus.out_colour;
      end
      @(posedge clk); #1;
    end
    timeout = (cyc >= 60000);
    bus.vga_plot = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
    bus.scan_start = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else pass_cnt++;
    tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    tot_cnt++; if (bus.scan_done !== 1'b0) $display("FAIL rst_scan_done: got %b want 0", bus.scan_done); else pass_cnt++;
    tot_cnt++; if (plot_count !== 16'd0 || drop_count !== 16'd0)
      $display("FAIL rst_counts: got %0d/%0d want 0/0", plot_count, drop_count); else pass_cnt++;
    tot_cnt++; if ({bus.out_x, bus.out_y, bus.out_colour} !== 18'd0)
      $display("FAIL rst_out_data: got %h want 0", {bus.out_x, bus.out_y, bus.out_colour}); else pass_cnt++;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 25000; c++) begin
      // A plot during the clear sweep must be dropped, not stored.
      if (c == 100) begin
        bus.vga_x = 8'd10; bus.vga_y = 7'd10; bus.vga_colour = 3'b111; bus.vga_plot = 1'b1;
      end else bus.vga_plot = 1'b0;
      @(posedge clk); #1;
      if (busy === 1'b1) n++; else break;
    end
    bus.vga_plot = 1'b0;
    tot_cnt++; if (n != NPIX) $display("FAIL clear_busy_cycles: got %0d want %0d", n, NPIX); else pass_cnt++;
    tot_cnt++; if (plot_count !== 16'd0 || drop_count !== 16'd1)
      $display("FAIL clear_drop_counts: got %0d/%0d want 0/1", plot_count, drop_count); else pass_cnt++;
    for (int i = 0; i < NPIX; i++) fb[i] = 3'b000;
  endtask

  task automatic test_blank_scan();
    int nz;
    scan_collect(0, 0, 0);
    nz = 0;
    for (int i = 0; i < NPIX; i++) if (cap[i] !== 3'b000) nz++;
    tot_cnt++; if (timeout) $display("FAIL blank_timeout: got beats %0d want %0d", beats, NPIX); else pass_cnt++;
    tot_cnt++; if (beats != NPIX) $display("FAIL blank_beats: got %0d want %0d", beats, NPIX); else pass_cnt++;
    tot_cnt++; if (first_lat != 2) $display("FAIL blank_first_latency: got %0d want 2", first_lat); else pass_cnt++;
    tot_cnt++; if (done_cnt != 1) $display("FAIL blank_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    tot_cnt++; if (done_lat != 1) $display("FAIL blank_done_latency: got %0d want 1", done_lat); else pass_cnt++;
    tot_cnt++; if (valid_at_done !== 1'b0) $display("FAIL blank_valid_at_done: got %b want 0", valid_at_done); else pass_cnt++;
    tot_cnt++; if (order_err != 0) $display("FAIL blank_raster_order: got %0d errors want 0", order_err); else pass_cnt++;
    tot_cnt++; if (nz != 0) $display("FAIL blank_colours: got %0d nonzero want 0", nz); else pass_cnt++;
  endtask

  task automatic test_plots_stall_collision();
    int nz;
    plot_one(8'd80,  7'd60,  3'b010);
    plot_one(8'd159, 7'd119, 3'b111);
    plot_one(8'd160, 7'd0,   3'b001);
    plot_one(8'd0,   7'd120, 3'b001);
    fb[9680] = 3'b010; fb[19199] = 3'b111;
    tot_cnt++; if (plot_count !== 16'd2) $display("FAIL plots_plot_count: got %0d want 2", plot_count); else pass_cnt++;
    tot_cnt++; if (drop_count !== 16'd3) $display("FAIL plots_drop_count: got %0d want 3", drop_count); else pass_cnt++;
    scan_collect(1, 1, 0);
    nz = 0;
    for (int i = 0; i < NPIX; i++)
      if (i != 9680 && i != 19199 && i != 19040 && cap[i] !== 3'b000) nz++;
    tot_cnt++; if (timeout || beats != NPIX) $display("FAIL stall_beats: got %0d want %0d", beats, NPIX); else pass_cnt++;
    tot_cnt++; if (stall_err != 0) $display("FAIL stall_hold: got %0d unstable beats want 0", stall_err); else pass_cnt++;
    tot_cnt++; if (order_err != 0) $display("FAIL stall_order: got %0d errors want 0", order_err); else pass_cnt++;
    tot_cnt++; if (done_cnt != 1) $display("FAIL stall_done_pulses: got %0d want 1", done_cnt); else pass_cnt++;
    tot_cnt++; if (cap[9680] !== 3'b010) $display("FAIL plot_80_60: got %b want 010", cap[9680]); else pass_cnt++;
    tot_cnt++; if (cap[19199] !== 3'b111) $display("FAIL plot_159_119: got %b want 111", cap[19199]); else pass_cnt++;
    tot_cnt++; if (cap[19040] !== 3'b101) $display("FAIL collide_unread: got %b want 101", cap[19040]); else pass_cnt++;
    tot_cnt++; if (cap[0] !== 3'b000) $display("FAIL collide_read: got %b want 000", cap[0]); else pass_cnt++;
    tot_cnt++; if (nz != 0) $display("FAIL plots_others: got %0d nonzero want 0", nz); else pass_cnt++;
    tot_cnt++; if (plot_count !== 16'd4) $display("FAIL collide_plot_count: got %0d want 4", plot_count); else pass_cnt++;
    fb[0] = 3'b110; fb[19040] = 3'b101;
  endtask

  task automatic test_circle();
    int x, y, err, strobes, acc, mism;
    int px [8];
    int py [8];
    logic [7:0] tx; logic [6:0] ty;
    logic [15:0] pc0, dc0;
    pc0 = plot_count; dc0 = drop_count;
    strobes = 0; acc = 0;
    x = 40; y = 0; err = 1 - 40;
    while (x >= y) begin
      px = '{x, y, -y, -x, -x, -y, y, x};
      py = '{y, x, x, y, -y, -x, -x, -y};
      for (int k = 0; k < 8; k++) begin
        // Negative coordinates wrap on the narrow bus; x wraps to >=216, but
        // y wraps to 88..127 and so may land on a real row.
        tx = 8'(px[k]); ty = 7'(py[k]);
        plot_one(tx, ty, 3'b011);
        strobes++;
        if (int'(tx) < W && int'(ty) < H) begin
          acc++;
          fb[int'(ty) * W + int'(tx)] = 3'b011;
        end
      end
      y++;
      if (err < 0) err += 2 * y + 1;
      else begin x--; err += 2 * (y - x) + 1; end
    end
    tot_cnt++; if (plot_count !== pc0 + 16'(acc))
      $display("FAIL circle_plot_count: got %0d want %0d", plot_count, pc0 + 16'(acc)); else pass_cnt++;
    tot_cnt++; if (drop_count !== dc0 + 16'(strobes - acc))
      $display("FAIL circle_drop_count: got %0d want %0d", drop_count, dc0 + 16'(strobes - acc)); else pass_cnt++;
    scan_collect(0, 0, 0);
    mism = 0;
    for (int i = 0; i < NPIX; i++) if (cap[i] !== fb[i]) mism++;
    tot_cnt++; if (timeout || beats != NPIX || done_cnt != 1)
      $display("FAIL rescan_beats: got %0d beats %0d done want %0d 1", beats, done_cnt, NPIX); else pass_cnt++;
    tot_cnt++; if (mism != 0) $display("FAIL rescan_frame: got %0d mismatched pixels want 0", mism); else pass_cnt++;
    tot_cnt++; if (cap[0] !== 3'b110) $display("FAIL rescan_0_0: got %b want 110", cap[0]); else pass_cnt++;
    tot_cnt++; if (cap[19040] !== 3'b101) $display("FAIL rescan_0_119: got %b want 101", cap[19040]); else pass_cnt++;
    tot_cnt++; if (cap[40] !== 3'b011) $display("FAIL circle_40_0: got %b want 011", cap[40]); else pass_cnt++;
    tot_cnt++; if (cap[40 * W] !== 3'b011) $display("FAIL circle_0_40: got %b want 011", cap[40 * W]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    int sd, ov;
    scan_collect(0, 0, 500);
    @(posedge clk); #1;
    tot_cnt++; if (beats != 500) $display("FAIL abort_beats: got %0d want 500", beats); else pass_cnt++;
    tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else pass_cnt++;
    tot_cnt++; if (plot_count !== 16'd0 || drop_count !== 16'd0)
      $display("FAIL abort_counts: got %0d/%0d want 0/0", plot_count, drop_count); else pass_cnt++;
    rst_n = 1'b1;
    sd = done_cnt; ov = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.scan_done === 1'b1) sd++;
      if (bus.out_valid === 1'b1) ov++;
      @(posedge clk); #1;
    end
    tot_cnt++; if (sd != 0) $display("FAIL abort_scan_done: got %0d pulses want 0", sd); else pass_cnt++;
    tot_cnt++; if (ov != 0) $display("FAIL abort_stream_resumed: got %0d valid cycles want 0", ov); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b1) $display("FAIL abort_clear_running: got %b want 1", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_plots_stall_collision();
    test_circle();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
